// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter giving one core at a time a single-cycle write
// into a shared register, followed by a one-cycle ack to that core.
module shared_reg_arbiter #(
    parameter int WIDTH = 12,
    parameter int N_CORES = 4,
    localparam int PTR_W = $clog2(N_CORES)
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic [N_CORES-1:0]         req,
    input  logic [N_CORES*WIDTH-1:0]   dataIn,
    output logic [N_CORES-1:0]         grant,
    output logic [N_CORES-1:0]         ack,
    output logic                       busy,
    output logic                       regWrEn,
    output logic [WIDTH-1:0]           regDataIn
);
    typedef enum logic [1:0] {IDLE, WRITE, ACK} stateT;
    stateT state;
    logic [PTR_W-1:0] ptr, winner, pick;
    // Scan from the far end back toward ptr so the last hit is the first set bit after ptr.
    always_comb begin
        pick = ptr;
        for (int k = N_CORES - 1; k >= 0; k--)
            if (req[PTR_W'((int'(ptr) + k) % N_CORES)]) pick = PTR_W'((int'(ptr) + k) % N_CORES);
    end
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= IDLE;
            ptr <= '0;
            winner <= '0;
            grant <= '0;
            ack <= '0;
            busy <= 1'b0;
            regWrEn <= 1'b0;
            regDataIn <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state <= WRITE;
                    winner <= pick;
                    regDataIn <= dataIn[pick*WIDTH +: WIDTH];
                    grant <= {{(N_CORES-1){1'b0}}, 1'b1} << pick;
                    busy <= 1'b1;
                    regWrEn <= 1'b1;
                end
                WRITE: begin
                    state <= ACK;
                    regWrEn <= 1'b0;
                    ack <= grant;
                end
                ACK: begin
                    state <= IDLE;
                    ptr <= winner == PTR_W'(N_CORES - 1) ? '0 : winner + 1'b1;
                    grant <= '0;
                    ack <= '0;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed vectors for the round-robin shared-register arbiter,
// with a model of the shared register and per-cycle invariant checks.
module tb_shared_reg_arbiter;
    localparam int WIDTH = 12;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*WIDTH-1:0] dataIn = {12'h3C3, 12'h5A3, 12'h0AB, 12'h111};
    logic [N-1:0] grant, ack;
    logic busy, regWrEn;
    logic [WIDTH-1:0] regDataIn;
    logic [WIDTH-1:0] regOut = '0;
    int nChecks = 0;
    int nPass = 0;
    bit mon = 1'b0;
    int w;

    shared_reg_arbiter #(.WIDTH(WIDTH), .N_CORES(N)) dut (
        .clk(clk), .rstN(rstN), .req(req), .dataIn(dataIn), .grant(grant), .ack(ack),
        .busy(busy), .regWrEn(regWrEn), .regDataIn(regDataIn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (regWrEn) regOut <= regDataIn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        if (mon)
            check("invariants", {27'd0,
                  (grant & (grant - 1'b1)) != 0,
                  (ack & (ack - 1'b1)) != 0,
                  (ack & ~grant) != 0,
                  regWrEn && (ack != 0),
                  regWrEn && !busy}, 32'd0);

    initial begin
        rstN = 1'b0;
        req = 4'b1111;
        step();
        step();
        check("rst grant", grant, 0);
        check("rst ack", ack, 0);
        check("rst busy", busy, 0);
        check("rst wren", regWrEn, 0);
        check("rst data", regDataIn, 0);
        mon = 1'b1;
        rstN = 1'b1;
        for (int t = 0; t < 5; t++) begin
            w = t % N;
            step();
            check("rr grant", grant, 4'b0001 << w);
            check("rr wren", regWrEn, 1);
            check("rr data", regDataIn, dataIn[w*WIDTH +: WIDTH]);
            step();
            check("rr ack", ack, 4'b0001 << w);
            check("rr wren off", regWrEn, 0);
            check("rr regout", regOut, dataIn[w*WIDTH +: WIDTH]);
            req[w] = 1'b0;
            step();
            check("rr idle busy", busy, 0);
            req[w] = 1'b1;
        end
        req = 4'b0100;
        step();
        check("single grant", grant, 4'b0100);
        check("single wren", regWrEn, 1);
        check("single data", regDataIn, 12'h5A3);
        step();
        check("single ack", ack, 4'b0100);
        check("single regout", regOut, 12'h5A3);
        req = 4'b0000;
        step();
        check("single idle", busy, 0);
        req = 4'b1001;
        step();
        check("wrap grant3", grant, 4'b1000);
        step();
        check("wrap ack3", ack, 4'b1000);
        req = 4'b0001;
        step();
        step();
        check("wrap grant0", grant, 4'b0001);
        step();
        check("wrap ack0", ack, 4'b0001);
        req = 4'b0000;
        step();
        req = 4'b0011;
        step();
        check("ptr1 grant", grant, 4'b0010);
        check("stable data", regDataIn, 12'h0AB);
        dataIn[WIDTH +: WIDTH] = 12'hFFF;
        req = 4'b1011;
        step();
        check("stable ack", ack, 4'b0010);
        check("stable regout", regOut, 12'h0AB);
        req = 4'b0001;
        step();
        check("idle grant", grant, 0);
        step();
        check("busy req ignored", grant, 4'b0001);
        step();
        check("busy req ack", ack, 4'b0001);
        req = 4'b0000;
        dataIn[WIDTH +: WIDTH] = 12'h0AB;
        step();
        req = 4'b0100;
        step();
        check("midw grant", grant, 4'b0100);
        rstN = 1'b0;
        step();
        check("midw wren", regWrEn, 0);
        check("midw ack", ack, 0);
        check("midw busy", busy, 0);
        check("midw grant0", grant, 0);
        rstN = 1'b1;
        req = 4'b0101;
        step();
        check("midw rearb", grant, 4'b0001);
        check("midw data", regDataIn, 12'h111);
        step();
        check("midw ack0", ack, 4'b0001);
        req = 4'b0100;
        step();
        step();
        check("mida grant", grant, 4'b0100);
        step();
        check("mida ack", ack, 4'b0100);
        rstN = 1'b0;
        req = 4'b1001;
        step();
        check("mida ack off", ack, 0);
        check("mida busy", busy, 0);
        check("mida grant off", grant, 0);
        rstN = 1'b1;
        step();
        check("mida ptr0", grant, 4'b0001);
        step();
        check("mida final ack", ack, 4'b0001);
        req = 4'b0000;
        step();
        check("final idle", busy, 0);
        mon = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
